uart_loader: RTL and testbench

- Byte-stream controller placed behind the UART receiver.
- Consumes the receiver's byte and valid-pulse output and parses a framed load packet: sync byte, 32-bit start address, 32-bit word count, then data words.
- Writes each assembled 32-bit word to memory through a ready handshake.
- Used to load programs into instruction/data memory over serial before the core is released.

---
 rtl/uart_loader.sv | 153 +++++++++++++++
 tb/tb_uart_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Serial program loader: parses a framed packet (sync, address, count, data words) from a
// byte stream and writes each little-endian word to memory through a ready handshake.
module uart_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [31:0] MAX_WORDS = 32'd65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StSync,
        StAddr,
        StLen,
        StData,
        StWrite,
        StDone,
        StError
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_q, hold_d;
    logic [31:0] len_full;
    logic        accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StSync;
            idx_q        <= 2'd0;
            addr_q       <= 32'd0;
            rem_q        <= 32'd0;
            wdata_q      <= 32'd0;
            hold_valid_q <= 1'b0;
            hold_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            wdata_q      <= wdata_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    // Count as it will read once the byte now arriving is merged in.
    assign len_full = {rx_data, rem_q[23:0]};
    assign accept   = (state_q == StWrite) && mem_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        wdata_d      = wdata_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;

        unique case (state_q)
            StSync: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = StAddr;
                    idx_d   = 2'd0;
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    addr_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = StLen;
                end
            end
            StLen: begin
                if (rx_valid) begin
                    rem_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (len_full == 32'd0)          state_d = StDone;
                        else if (len_full > MAX_WORDS)  state_d = StError;
                        else                            state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                if (accept) begin
                    addr_d       = addr_q + 32'd4;
                    rem_d        = rem_q - 32'd1;
                    hold_valid_d = 1'b0;
                    if (rem_q == 32'd1) begin
                        state_d = StDone;
                    end else begin
                        state_d = StData;
                        // Bytes that arrived during the stall start the next word.
                        unique case ({hold_valid_q, rx_valid})
                            2'b00: idx_d = 2'd0;
                            2'b01: begin
                                wdata_d[7:0] = rx_data;
                                idx_d        = 2'd1;
                            end
                            2'b10: begin
                                wdata_d[7:0] = hold_q;
                                idx_d        = 2'd1;
                            end
                            default: begin
                                wdata_d[15:0] = {rx_data, hold_q};
                                idx_d         = 2'd2;
                            end
                        endcase
                    end
                end else if (rx_valid) begin
                    if (hold_valid_q) begin
                        state_d = StError;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_d       = rx_data;
                    end
                end
            end
            StDone:  state_d = StSync;
            StError: state_d = StError;
            default: state_d = StSync;
        endcase
    end

    assign mem_wen   = (state_q == StWrite);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);
    assign busy      = (state_q != StSync) && (state_q != StError);

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: expected writes are queued as packets are driven and
// popped as the memory interface accepts them.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        error;

    uart_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_done   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int done_cyc = 0;
    logic [63:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs are stable from posedge+1, so a negedge sample predicts the next edge's acceptance.
    always @(negedge clk) begin
        if (!reset && mem_wen && mem_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {31'd0, mem_wen}, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
            n_writes++;
            acc_cyc = cyc;
        end
        if (!reset && done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [31:0] n);
        send_byte(8'hA5);
        send_word(a);
        send_word(n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string tag);
        int k = 0;
        while (n_writes < target && k < 200) begin
            tick(1);
            k++;
        end
        if (n_writes < target) check(tag, n_writes, target);
    endtask

    int w0;
    int d0;

    initial begin
        reset     = 1'b1;
        rx_data   = 8'd0;
        rx_valid  = 1'b0;
        mem_ready = 1'b1;
        tick(3);
        check("rst_wen", {31'd0, mem_wen}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Basic two-word packet.
        w0 = n_writes; d0 = n_done;
        sb.push_back({32'h0000_1000, 32'h1234_5678});
        sb.push_back({32'h0000_1004, 32'hDEAD_BEEF});
        send_hdr(32'h0000_1000, 32'd2);
        check("a_busy", {31'd0, busy}, 32'd1);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        tick(4);
        check("a_writes", n_writes - w0, 2);
        check("a_done_cnt", n_done - d0, 1);
        check("a_done_lat", done_cyc - acc_cyc, 1);
        check("a_busy_after", {31'd0, busy}, 32'd0);
        check("a_error", {31'd0, error}, 32'd0);

        // Junk ahead of sync.
        w0 = n_writes;
        send_byte(8'h00);
        send_byte(8'hFF);
        sb.push_back({32'h0000_2000, 32'hCAFE_F00D});
        send_hdr(32'h0000_2000, 32'd1);
        send_word(32'hCAFE_F00D);
        tick(4);
        check("junk_writes", n_writes - w0, 1);

        // Zero count.
        w0 = n_writes; d0 = n_done;
        send_hdr(32'h0000_5000, 32'd0);
        tick(3);
        check("zero_done", n_done - d0, 1);
        check("zero_writes", n_writes - w0, 0);

        // Count just above the limit.
        w0 = n_writes;
        send_hdr(32'h0000_6000, 32'h0001_0001);
        tick(2);
        check("max_error", {31'd0, error}, 32'd1);
        check("max_busy", {31'd0, busy}, 32'd0);
        send_word(32'h0102_0304);
        tick(2);
        check("max_writes", n_writes - w0, 0);
        check("max_sticky", {31'd0, error}, 32'd1);
        do_reset();
        check("max_rst_error", {31'd0, error}, 32'd0);

        // Address wrap.
        w0 = n_writes;
        sb.push_back({32'hFFFF_FFFC, 32'h1111_1111});
        sb.push_back({32'h0000_0000, 32'h2222_2222});
        send_hdr(32'hFFFF_FFFC, 32'd2);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        tick(4);
        check("wrap_writes", n_writes - w0, 2);

        // Reset after first acceptance aborts the packet.
        w0 = n_writes;
        sb.push_back({32'hFFFF_FFFC, 32'h3333_3333});
        send_hdr(32'hFFFF_FFFC, 32'd2);
        send_word(32'h3333_3333);
        wait_writes(w0 + 1, "abort_wait");
        do_reset();
        check("abort_addr", mem_addr, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        send_word(32'h4444_4444);
        tick(4);
        check("abort_writes", n_writes - w0, 1);

        // Hold overflow during a stalled write.
        w0 = n_writes;
        mem_ready = 1'b0;
        send_hdr(32'h0000_3000, 32'd1);
        send_word(32'h0BAD_F00D);
        send_byte(8'h11);
        check("ovf_no_err_yet", {31'd0, error}, 32'd0);
        send_byte(8'h22);
        check("ovf_error", {31'd0, error}, 32'd1);
        tick(14);
        mem_ready = 1'b1;
        tick(5);
        check("ovf_wen", {31'd0, mem_wen}, 32'd0);
        check("ovf_sticky", {31'd0, error}, 32'd1);
        check("ovf_writes", n_writes - w0, 0);
        do_reset();

        // One byte held during stall, one concurrent with acceptance.
        w0 = n_writes;
        mem_ready = 1'b0;
        sb.push_back({32'h0000_4000, 32'h0102_0304});
        sb.push_back({32'h0000_4004, 32'h4433_2211});
        send_hdr(32'h0000_4000, 32'd2);
        send_word(32'h0102_0304);
        send_byte(8'h11);
        tick(6);
        rx_data   = 8'h22;
        rx_valid  = 1'b1;
        mem_ready = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(1);
        send_byte(8'h33);
        send_byte(8'h44);
        tick(4);
        check("hold_writes", n_writes - w0, 2);
        check("hold_error", {31'd0, error}, 32'd0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
